pc_fetch_unit: RTL and testbench

Program-counter and fetch-control stage for the single-cycle RV32I CPU. It sits directly upstream of the instruction ROM and drives its 10-bit word address. It selects the next PC from sequential, branch, JAL and JALR sources, and halts and resumes the core on system-call requests. It also flags misaligned control-flow targets and counts executed cycles.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/pc_next_sel.sv | 27 ++
 rtl/pc_fetch_unit.sv | 86 ++++++++
 tb/tb_pc_fetch_unit.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the PC/fetch stage
package cpu_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    HALT  = 2'b01,
    FAULT = 2'b10
  } pc_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int          ROM_ADDR_W       = 10;

endpackage

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - combinational target adder and next-PC priority mux
module pc_next_sel
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  input  logic [31:0] rs1,
  input  logic        jalr,
  input  logic        jal,
  input  logic        branch_taken,
  output logic [31:0] next_pc,
  output logic        misalign
);

  always_comb begin
    next_pc  = pc + 32'd4;
    misalign = 1'b0;
    if (jalr) begin
      next_pc  = (rs1 + imm) & ~32'd1;
      misalign = next_pc[1];
    end else if (jal || branch_taken) begin
      next_pc  = pc + imm;
      misalign = next_pc[1];
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC register, run/halt/fault FSM, go edge detect, cycle counter
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          ADDR_W   = ROM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic              halt_req,
  input  logic              branch_taken,
  input  logic              jal,
  input  logic              jalr,
  input  logic [31:0]       imm,
  input  logic [31:0]       rs1,
  output logic [31:0]       pc,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [31:0]       pc_plus4,
  output logic              halted,
  output logic              fault,
  output logic [31:0]       cycle_cnt
);

  pc_state_t   state, state_next;
  logic [31:0] pc_d;
  logic [31:0] sel_pc;
  logic        sel_misalign;
  logic        go_q;
  logic        go_rise;

  pc_next_sel u_sel (
    .pc           (pc),
    .imm          (imm),
    .rs1          (rs1),
    .jalr         (jalr),
    .jal          (jal),
    .branch_taken (branch_taken),
    .next_pc      (sel_pc),
    .misalign     (sel_misalign)
  );

  assign rom_addr = pc[ADDR_W+1:2];
  assign pc_plus4 = pc + 32'd4;
  assign go_rise  = go & ~go_q;

  // Halt wins over a misaligned target: the ecall never retires.
  always_comb begin
    state_next = state;
    pc_d       = pc;
    case (state)
      RUN: begin
        if (halt_req)          state_next = HALT;
        else if (sel_misalign) state_next = FAULT;
        else                   pc_d       = sel_pc;
      end
      HALT: begin
        if (go_rise) begin
          state_next = RUN;
          pc_d       = pc_plus4;
        end
      end
      FAULT:   state_next = FAULT;
      default: state_next = FAULT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      pc        <= RESET_PC;
      go_q      <= 1'b0;
      cycle_cnt <= 32'd0;
      halted    <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state  <= state_next;
      pc     <= pc_d;
      go_q   <= go;
      halted <= (state_next == HALT);
      fault  <= (state_next == FAULT);
      if (state == RUN) cycle_cnt <= cycle_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - scoreboard bench for pc_fetch_unit
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        go = 1'b0;
  logic        halt_req = 1'b0;
  logic        branch_taken = 1'b0;
  logic        jal = 1'b0;
  logic        jalr = 1'b0;
  logic [31:0] imm = 32'd0;
  logic [31:0] rs1 = 32'd0;
  logic [31:0] pc;
  logic [9:0]  rom_addr;
  logic [31:0] pc_plus4;
  logic        halted;
  logic        fault;
  logic [31:0] cycle_cnt;

  typedef struct {
    logic [31:0] pc;
    logic        halted;
    logic        fault;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  pc_fetch_unit #(.RESET_PC(32'h0), .ADDR_W(10)) dut (
    .clk          (clk),
    .reset        (reset),
    .go           (go),
    .halt_req     (halt_req),
    .branch_taken (branch_taken),
    .jal          (jal),
    .jalr         (jalr),
    .imm          (imm),
    .rs1          (rs1),
    .pc           (pc),
    .rom_addr     (rom_addr),
    .pc_plus4     (pc_plus4),
    .halted       (halted),
    .fault        (fault),
    .cycle_cnt    (cycle_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares the post-edge outputs against the oldest expectation
  initial begin
    exp_t e;
    logic [31:0] exp_rom;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        exp_rom = {22'd0, e.pc[11:2]};
        chk("pc",        pc,                e.pc);
        chk("rom_addr",  {22'd0, rom_addr}, exp_rom);
        chk("pc_plus4",  pc_plus4,          e.pc + 32'd4);
        chk("halted",    {31'd0, halted},   {31'd0, e.halted});
        chk("fault",     {31'd0, fault},    {31'd0, e.fault});
        chk("cycle_cnt", cycle_cnt,         e.cnt);
      end
    end
  end

  task automatic step(input logic r, g, hr, br, jl, jr,
                      input logic [31:0] im, r1,
                      input logic [31:0] epc, input logic eh, ef,
                      input logic [31:0] ec);
    exp_t e;
    @(negedge clk);
    reset = r; go = g; halt_req = hr; branch_taken = br;
    jal = jl; jalr = jr; imm = im; rs1 = r1;
    e.pc = epc; e.halted = eh; e.fault = ef; e.cnt = ec;
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    //    r g hr br jl jr imm            rs1            pc             h f cnt
    step(1,0,0, 0, 0, 0, 32'h0,         32'h0,         32'h0,         0,0,32'd0);
    step(1,0,0, 0, 0, 0, 32'h0,         32'h0,         32'h0,         0,0,32'd0);
    step(0,0,0, 0, 0, 0, 32'h0,         32'h0,         32'h4,         0,0,32'd1);
    step(0,0,0, 0, 0, 0, 32'h0,         32'h0,         32'h8,         0,0,32'd2);
    step(0,0,0, 0, 0, 0, 32'h0,         32'h0,         32'hC,         0,0,32'd3);
    step(0,0,0, 0, 1, 0, 32'h38,        32'h0,         32'h44,        0,0,32'd4);
    step(0,0,0, 0, 1, 0, 32'h29C,       32'h0,         32'h2E0,       0,0,32'd5);
    step(0,0,0, 1, 0, 0, 32'hFFFF_FD84, 32'h0,         32'h64,        0,0,32'd6);
    step(0,0,0, 1, 0, 0, 32'hFFFF_FFEC, 32'h0,         32'h50,        0,0,32'd7);
    step(0,0,0, 0, 0, 1, 32'h0,         32'h49,        32'h48,        0,0,32'd8);
    // jalr outranks jal/branch
    step(0,0,0, 1, 1, 1, 32'h10,        32'h100,       32'h110,       0,0,32'd9);
    step(0,0,0, 0, 0, 1, 32'h9,         32'h2D0,       32'h2D8,       0,0,32'd10);
    // halt outranks a misaligned jal
    step(0,0,1, 0, 1, 0, 32'h6,         32'h0,         32'h2D8,       1,0,32'd11);
    for (int i = 0; i < 10; i++)
      step(0,0,1, 1, 1, 1, 32'h8,       32'h40,        32'h2D8,       1,0,32'd11);
    step(0,1,0, 0, 0, 0, 32'h0,         32'h0,         32'h2DC,       0,0,32'd11);
    step(0,1,0, 0, 0, 0, 32'h0,         32'h0,         32'h2E0,       0,0,32'd12);
    step(0,1,0, 0, 0, 0, 32'h0,         32'h0,         32'h2E4,       0,0,32'd13);
    step(0,1,0, 0, 0, 0, 32'h0,         32'h0,         32'h2E8,       0,0,32'd14);
    // go still high on halt entry: not an edge
    step(0,1,1, 0, 0, 0, 32'h0,         32'h0,         32'h2E8,       1,0,32'd15);
    for (int i = 0; i < 3; i++)
      step(0,1,0, 0, 0, 0, 32'h0,       32'h0,         32'h2E8,       1,0,32'd15);
    step(0,0,0, 0, 0, 0, 32'h0,         32'h0,         32'h2E8,       1,0,32'd15);
    step(0,1,0, 0, 0, 0, 32'h0,         32'h0,         32'h2EC,       0,0,32'd15);
    step(0,0,0, 0, 0, 1, 32'h0,         32'h10,        32'h10,        0,0,32'd16);
    // misaligned jal -> sticky fault
    step(0,0,0, 0, 1, 0, 32'h6,         32'h0,         32'h10,        0,1,32'd17);
    step(0,1,0, 0, 0, 0, 32'h0,         32'h0,         32'h10,        0,1,32'd17);
    step(0,0,0, 0, 0, 0, 32'h0,         32'h0,         32'h10,        0,1,32'd17);
    step(0,1,1, 0, 0, 1, 32'h0,         32'h0,         32'h10,        0,1,32'd17);
    step(1,1,0, 0, 0, 0, 32'h0,         32'h0,         32'h0,         0,0,32'd0);
    // go held high through reset, then halt
    step(0,1,0, 0, 0, 0, 32'h0,         32'h0,         32'h4,         0,0,32'd1);
    step(0,1,1, 0, 0, 0, 32'h0,         32'h0,         32'h4,         1,0,32'd2);
    for (int i = 0; i < 3; i++)
      step(0,1,0, 0, 0, 0, 32'h0,       32'h0,         32'h4,         1,0,32'd2);
    step(0,0,0, 0, 0, 0, 32'h0,         32'h0,         32'h4,         1,0,32'd2);
    step(0,1,0, 0, 0, 0, 32'h0,         32'h0,         32'h8,         0,0,32'd2);
    step(0,1,1, 0, 0, 0, 32'h0,         32'h0,         32'h8,         1,0,32'd3);
    // reset mid-halt with go high, go still high afterwards
    step(1,1,0, 0, 0, 0, 32'h0,         32'h0,         32'h0,         0,0,32'd0);
    step(0,1,0, 0, 0, 0, 32'h0,         32'h0,         32'h4,         0,0,32'd1);
    step(0,0,0, 1, 0, 0, 32'h2,         32'h0,         32'h4,         0,1,32'd2);
    step(1,0,0, 0, 0, 0, 32'h0,         32'h0,         32'h0,         0,0,32'd0);
    step(0,0,0, 0, 0, 1, 32'h0,         32'h3,         32'h0,         0,1,32'd1);
    step(1,0,0, 0, 0, 0, 32'h0,         32'h0,         32'h0,         0,0,32'd0);
    // rom_addr truncation and 32-bit wrap
    step(0,0,0, 0, 1, 0, 32'h1000,      32'h0,         32'h1000,      0,0,32'd1);
    step(0,0,0, 0, 0, 0, 32'h0,         32'h0,         32'h1004,      0,0,32'd2);
    step(0,0,0, 0, 1, 0, 32'hFFFF_F000, 32'h0,         32'h4,         0,0,32'd3);
    #3;
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
